// File: rtl/encoder_8x3_reg.sv
// Registered 8-to-3 encoder for one-hot select vectors, with an input-valid
// flag and a multi-hot error flag. All outputs change one clk edge after d
// is sampled.
//
// Optional feature macro: ENCODER_PRIORITY_EN
//   undefined : OR-encoder. A multi-hot input gives the bitwise OR of the
//               indices of all set bits.
//   defined   : priority encoder. The index of the highest set bit wins, so
//               d[7] has the highest priority.
// One-hot inputs, valid, err, reset and latency are the same in both builds.
module encoder_8x3_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid,
  output logic       err
);

  logic [2:0] idx_d, idx_q;
  logic       valid_d, valid_q;
  logic       err_d, err_q;
  logic [7:0] d_less_one;

  // Clearing the lowest set bit leaves a nonzero value exactly when two or
  // more bits are set.
  assign d_less_one = d - 8'd1;

  // Combinational encode of the current sample.
  always_comb begin
    idx_d   = 3'd0;
    valid_d = |d;
    err_d   = |(d & d_less_one);
`ifdef ENCODER_PRIORITY_EN
    // Scan upward so that the highest set bit is the last one to assign.
    for (int i = 0; i < 8; i++) begin
      if (d[i]) idx_d = i[2:0];
    end
`else
    idx_d[2] = d[4] | d[5] | d[6] | d[7];
    idx_d[1] = d[2] | d[3] | d[6] | d[7];
    idx_d[0] = d[1] | d[3] | d[5] | d[7];
`endif
  end

  // Output register. Reset is synchronous and overrides the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign a     = idx_q[2];
  assign b     = idx_q[1];
  assign c     = idx_q[0];
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_encoder_8x3_reg.sv
// Directed-vector bench for encoder_8x3_reg. Expected values are packed as
// {a,b,c,valid,err}. Vectors that differ between the OR-encoder and the
// priority encoder follow ENCODER_PRIORITY_EN.
module tb_encoder_8x3_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d   = 8'h00;
  logic       a, b, c, valid, err;

  int n_checks = 0;
  int n_errors = 0;

  encoder_8x3_reg dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .a    (a),
    .b    (b),
    .c    (c),
    .valid(valid),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got {a,b,c,v,e}=%b expected %b", tag, obs, exp_v);
    end
  endtask

  // Apply one sample, let a rising edge capture it, then check the outputs
  // 1 ns after that edge.
  task automatic step(input string tag, input logic r, input logic [7:0] dv,
                      input logic [4:0] exp_v);
    rst = r;
    d   = dv;
    @(posedge clk);
    #1;
    check_val(tag, {a, b, c, valid, err}, exp_v);
  endtask

  logic [7:0] walk [8];

  initial begin
    for (int k = 0; k < 8; k++) walk[k] = 8'(1 << k);

    // Reset held for two cycles while d is all ones.
    step("rst0", 1'b1, 8'hFF, 5'b000_0_0);
    step("rst1", 1'b1, 8'hFF, 5'b000_0_0);
    step("rst_release", 1'b0, 8'hFF, 5'b111_1_1);

    // One-hot walk.
    step("hot0", 1'b0, 8'h01, 5'b000_1_0);
    step("hot1", 1'b0, 8'h02, 5'b001_1_0);
    step("hot2", 1'b0, 8'h04, 5'b010_1_0);
    step("hot3", 1'b0, 8'h08, 5'b011_1_0);
    step("hot4", 1'b0, 8'h10, 5'b100_1_0);
    step("hot5", 1'b0, 8'h20, 5'b101_1_0);
    step("hot6", 1'b0, 8'h40, 5'b110_1_0);
    step("hot7", 1'b0, 8'h80, 5'b111_1_0);

    // Zero input compared with d=0x01.
    step("zero", 1'b0, 8'h00, 5'b000_0_0);
    step("one",  1'b0, 8'h01, 5'b000_1_0);

    // The registered outputs must not follow d between edges.
    #2 d = 8'h80;
    #1 check_val("hold", {a, b, c, valid, err}, 5'b000_1_0);

    // Multi-hot inputs.
    step("mh03", 1'b0, 8'h03, 5'b001_1_1);
`ifdef ENCODER_PRIORITY_EN
    step("mh12", 1'b0, 8'h12, 5'b100_1_1);
    step("mh06", 1'b0, 8'h06, 5'b010_1_1);
    step("mh50", 1'b0, 8'h50, 5'b110_1_1);
`else
    step("mh12", 1'b0, 8'h12, 5'b101_1_1);
    step("mh06", 1'b0, 8'h06, 5'b011_1_1);
    step("mh50", 1'b0, 8'h50, 5'b110_1_1);
`endif
    step("mhFF", 1'b0, 8'hFF, 5'b111_1_1);
    step("mh81", 1'b0, 8'h81, 5'b111_1_1);

    // Mid-stream reset: reset the 0x10 sample, then continue the walk.
    for (int k = 0; k < 4; k++)
      step("walk_pre", 1'b0, walk[k], {3'(k), 2'b10});
    step("mid_rst", 1'b1, 8'h10, 5'b000_0_0);
    step("post_rst", 1'b0, 8'h20, 5'b101_1_0);
    step("post_rst2", 1'b0, 8'h40, 5'b110_1_0);

    // Alternate 0x80 and 0x01 on every cycle.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step("alt80", 1'b0, 8'h80, 5'b111_1_0);
      else            step("alt01", 1'b0, 8'h01, 5'b000_1_0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_8x3_reg.md
Name: encoder_8x3_reg

Overview:
- Registered 8-to-3 binary encoder for one-hot select vectors; converts an 8-bit one-hot input into a 3-bit index split across outputs a (MSB), b, c (LSB).
- Adds an input-valid flag and a multi-hot error flag.
- Sits between one-hot request/select logic and index-consuming datapath logic; all outputs update on the clock edge after the input is sampled.

Parameters:
- None. Widths are fixed: 8-bit input, 3-bit index.

Ports:
- clk    input   1  rising-edge clock
- rst    input   1  synchronous reset, active-high
- d      input   8  one-hot input vector; d[0] maps to index 0, d[7] maps to index 7
- a      output  1  index bit 2 (MSB), registered
- b      output  1  index bit 1, registered
- c      output  1  index bit 0 (LSB), registered
- valid  output  1  registered; 1 when at least one bit of d was set
- err    output  1  registered; 1 when more than one bit of d was set

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
  - rst sampled high at a rising edge of clk forces a=b=c=0, valid=0 and err=0 on that edge.
  - rst has no asynchronous effect.
  - rst has priority over every other input.
  - Asserting rst mid-stream discards the pending encode; the first sample after rst deasserts is encoded normally.
- Latency: exactly 1 clk cycle. The value of d at rising edge N appears on a/b/c/valid/err after edge N. No handshake; a new d is accepted every cycle.
- Default encoding (OR-encoder, optional feature absent):
  - a = d[4]|d[5]|d[6]|d[7]
  - b = d[2]|d[3]|d[6]|d[7]
  - c = d[1]|d[3]|d[5]|d[7]
- One-hot input d = 1<<k gives {a,b,c} = k for k = 0..7.
- valid = |d.
- err = 1 when popcount(d) >= 2; otherwise 0.
- d = 0x00: {a,b,c}=000, valid=0, err=0. The index for d=0x01 is also 000, so consumers use valid to distinguish the two cases.
- Multi-hot input in default mode: {a,b,c} is the bitwise OR of the indices of all set bits (e.g. 0x03 -> 001, 0x12 -> 101), err=1, valid=1.
- Outputs hold their value until the next clock edge; they do not glitch with d between edges.
- X/Z on d is not required to be handled; the bench drives only known values.

Optional Feature:
- Macro: ENCODER_PRIORITY_EN
- Defined: priority encoder. {a,b,c} = index of the highest set bit of d; d[7] has highest priority.
  - Example: 0x03 -> 001, 0x12 -> 100, 0xFF -> 111.
  - valid and err are computed exactly as in default mode.
  - One-hot results are identical to default mode.
- Undefined: OR-encoder as specified in Behaviour.
- Reset behaviour and latency are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with d=0xFF -> a=b=c=0, valid=0, err=0 while reset is applied. Release rst -> after the next edge {a,b,c}=111, valid=1, err=1.
- One-hot walk: d = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80 on consecutive cycles -> {a,b,c} = 000, 001, 010, 011, 100, 101, 110, 111, each one cycle later; valid=1 and err=0 throughout.
- Zero input: d=0x00 -> {a,b,c}=000, valid=0, err=0. Compare with d=0x01 -> 000, valid=1.
- Multi-hot: d=0x03 -> err=1, valid=1; {a,b,c}=001 in default build, 001 in priority build. d=0x12 -> 101 in default build, 100 in priority build.
- Mid-stream reset: drive the one-hot walk and assert rst for one cycle at d=0x10 -> that cycle's outputs are 0/0/0, valid=0. The following d=0x20 yields 101 with valid=1.
- Back-to-back change: alternate d between 0x80 and 0x01 every cycle -> {a,b,c} alternates 111/000 with exactly one-cycle lag and no skipped samples.
